// File: rtl/lift_pkg.sv
// Shared constants for the hall-call encoder and the lift FSM: direction codes,
// request codes, controller states and the call-index lookup helpers.
package lift_pkg;

    localparam logic [1:0] DIR_UP   = 2'b00;
    localparam logic [1:0] DIR_DOWN = 2'b01;
    localparam logic [1:0] DIR_STAY = 2'b10;

    localparam logic [2:0] REQ_NONE = 3'b000;
    localparam logic [2:0] REQ_1U   = 3'b001;
    localparam logic [2:0] REQ_2U   = 3'b010;
    localparam logic [2:0] REQ_3U   = 3'b011;
    localparam logic [2:0] REQ_2D   = 3'b110;
    localparam logic [2:0] REQ_3D   = 3'b111;
    localparam logic [2:0] REQ_4D   = 3'b100;

    localparam int NUM_CALLS = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DWELL = 2'd2
    } lift_state_t;

    // Call index order: 1U, 2U, 3U, 2D, 3D, 4D.
    function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return REQ_1U;
            3'd1:    return REQ_2U;
            3'd2:    return REQ_3U;
            3'd3:    return REQ_2D;
            3'd4:    return REQ_3D;
            3'd5:    return REQ_4D;
            default: return REQ_NONE;
        endcase
    endfunction

    // Target floor in floor-sensor encoding (00 = floor 1).
    function automatic logic [1:0] idx_to_floor(input logic [2:0] idx);
        case (idx)
            3'd0:    return 2'b00;
            3'd1:    return 2'b01;
            3'd2:    return 2'b10;
            3'd3:    return 2'b01;
            3'd4:    return 2'b10;
            3'd5:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/lift_rr_arbiter.sv
// Combinational round-robin pick over the six latched hall calls, searching
// upward from rr_ptr and wrapping index 5 back to 0.
module lift_rr_arbiter
    import lift_pkg::*;
(
    input  logic [5:0] pending,
    input  logic [2:0] rr_ptr,
    output logic [2:0] grant_idx,
    output logic       grant_vld
);

    logic [3:0] cand;

    // Walk offsets from farthest to nearest so the nearest pending call wins.
    always_comb begin
        grant_idx = 3'd0;
        grant_vld = 1'b0;
        cand      = 4'd0;
        for (int i = NUM_CALLS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + 4'(i);
            if (cand >= 4'(NUM_CALLS)) begin
                cand = cand - 4'(NUM_CALLS);
            end
            if (pending[cand[2:0]]) begin
                grant_idx = cand[2:0];
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_call_encoder.sv
// Hall-call front end: latches buttons, issues one encoded request at a time and
// retires it after a door dwell. LIFT_CALL_TIMEOUT_EN adds an ISSUE timeout.
module lift_call_encoder
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_up,
    input  logic [2:0] btn_dn,
    input  logic [1:0] lift_dir,
    input  logic [1:0] floor_at,
    output logic [2:0] req_code,
    output logic       req_valid,
    output logic       served,
    output logic [5:0] pending,
    output logic       timeout_err
);

    generate
        if (DWELL_CYCLES < 1 || DWELL_CYCLES > 255) begin : g_bad_dwell
            $error("DWELL_CYCLES must be 1..255");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be 1..65535");
        end
    endgenerate

    lift_state_t state, state_nxt;
    logic [2:0]  active, active_nxt;
    logic [2:0]  rr_ptr, rr_ptr_nxt;
    logic [7:0]  dwell_cnt, dwell_nxt;
    logic [2:0]  req_code_nxt;
    logic        served_nxt;
    logic [5:0]  clr_mask;
    logic [2:0]  grant_idx;
    logic        grant_vld;
    logic        timeout_hit;
    logic        arrived;

    lift_rr_arbiter u_arb (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign arrived   = (floor_at == idx_to_floor(active)) && (lift_dir == DIR_STAY);
    assign req_valid = |req_code;

    always_comb begin
        state_nxt    = state;
        active_nxt   = active;
        rr_ptr_nxt   = rr_ptr;
        dwell_nxt    = dwell_cnt;
        req_code_nxt = req_code;
        served_nxt   = 1'b0;
        clr_mask     = 6'd0;
        case (state)
            ST_IDLE: begin
                req_code_nxt = REQ_NONE;
                if (grant_vld) begin
                    active_nxt   = grant_idx;
                    req_code_nxt = idx_to_code(grant_idx);
                    state_nxt    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (arrived) begin
                    dwell_nxt = 8'(DWELL_CYCLES - 1);
                    state_nxt = ST_DWELL;
                end else if (timeout_hit) begin
                    // Abandoned call stays pending; move the pointer past it.
                    rr_ptr_nxt   = next_idx(active);
                    req_code_nxt = REQ_NONE;
                    state_nxt    = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (dwell_cnt == 8'd0) begin
                    clr_mask     = 6'b000001 << active;
                    served_nxt   = 1'b1;
                    rr_ptr_nxt   = next_idx(active);
                    req_code_nxt = REQ_NONE;
                    state_nxt    = ST_IDLE;
                end else begin
                    dwell_nxt = dwell_cnt - 8'd1;
                end
            end
            default: begin
                req_code_nxt = REQ_NONE;
                state_nxt    = ST_IDLE;
            end
        endcase
    end

    // Clear is applied after the OR so a retire beats a same-cycle press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            active    <= 3'd0;
            rr_ptr    <= 3'd0;
            dwell_cnt <= 8'd0;
            req_code  <= REQ_NONE;
            served    <= 1'b0;
            pending   <= 6'd0;
        end else begin
            state     <= state_nxt;
            active    <= active_nxt;
            rr_ptr    <= rr_ptr_nxt;
            dwell_cnt <= dwell_nxt;
            req_code  <= req_code_nxt;
            served    <= served_nxt;
            pending   <= (pending | {btn_dn, btn_up}) & ~clr_mask;
        end
    end

`ifdef LIFT_CALL_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_err;

    assign timeout_hit = (state == ST_ISSUE) && (to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = to_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= 16'd0;
            to_err <= 1'b0;
        end else begin
            if (state == ST_ISSUE && !timeout_hit) begin
                to_cnt <= to_cnt + 16'd1;
            end else begin
                to_cnt <= 16'd0;
            end
            if (timeout_hit && state_nxt == ST_IDLE) begin
                to_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_lift_call_encoder.sv
// Directed + randomized bench for lift_call_encoder against a call-list model
// (pending set, round-robin pointer, dwell timing) kept in the bench.
module tb_lift_call_encoder;

    localparam int DWELL = 8;
`ifdef LIFT_CALL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] btn_up = 3'd0;
    logic [2:0] btn_dn = 3'd0;
    logic [1:0] lift_dir = 2'b00;
    logic [1:0] floor_at = 2'b00;
    logic [2:0] req_code;
    logic       req_valid;
    logic       served;
    logic [5:0] pending;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    // Index order 1U,2U,3U,2D,3D,4D: request code and target floor (0 = floor 1).
    int code_tab[6]  = '{1, 2, 3, 6, 7, 4};
    int floor_tab[6] = '{0, 1, 2, 1, 2, 3};
    bit m_pend[6];
    int m_ptr = 0;

    lift_call_encoder #(
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_up      (btn_up),
        .btn_dn      (btn_dn),
        .lift_dir    (lift_dir),
        .floor_at    (floor_at),
        .req_code    (req_code),
        .req_valid   (req_valid),
        .served      (served),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] model_vec();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int model_grant();
        for (int i = 0; i < 6; i++) begin
            if (m_pend[(m_ptr + i) % 6]) return (m_ptr + i) % 6;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_pend[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic press(input logic [5:0] mask);
        btn_up = mask[2:0];
        btn_dn = mask[5:3];
        tick();
        btn_up = 3'd0;
        btn_dn = 3'd0;
        for (int i = 0; i < 6; i++) if (mask[i]) m_pend[i] = 1'b1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_valid_rise", {31'd0, req_valid}, 32'd1);
    endtask

    // Serve the call the model says is next; 'extra' cycles of non-arrival first.
    task automatic serve_next(input int extra, input bit noise);
        int g;
        logic [5:0] nmask;
        g = model_grant();
        if (g < 0) begin
            chk("model_has_call", 32'd0, 32'd1);
            return;
        end
        wait_valid();
        chk("grant_code", {29'd0, req_code}, code_tab[g]);
        for (int k = 0; k < extra; k++) begin
            lift_dir = (k % 2 == 0) ? 2'b00 : 2'b10;
            floor_at = 2'((floor_tab[g] + 1 + (k % 3)) % 4);
            if (noise && k == 0) begin
                nmask = 6'($urandom_range(0, 63));
                press(nmask);
            end else begin
                tick();
            end
            chk("issue_hold", {29'd0, req_code}, code_tab[g]);
            chk("issue_no_served", {31'd0, served}, 32'd0);
        end
        floor_at = 2'(floor_tab[g]);
        lift_dir = 2'b10;
        tick();
        lift_dir = 2'b00;
        chk("arrive_no_served", {31'd0, served}, 32'd0);
        for (int k = 1; k < DWELL; k++) begin
            tick();
            chk("dwell_no_served", {31'd0, served}, 32'd0);
            chk("dwell_hold", {29'd0, req_code}, code_tab[g]);
        end
        tick();
        m_pend[g] = 1'b0;
        m_ptr = (g + 1) % 6;
        chk("served_pulse", {31'd0, served}, 32'd1);
        chk("retire_code_none", {29'd0, req_code}, 32'd0);
        chk("retire_valid_low", {31'd0, req_valid}, 32'd0);
        chk("retire_pending", {26'd0, pending}, {26'd0, model_vec()});
        tick();
        chk("served_one_cycle", {31'd0, served}, 32'd0);
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        chk("rst_code", {29'd0, req_code}, 32'd0);
        chk("rst_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_pending", {26'd0, pending}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle_code", {29'd0, req_code}, 32'd0);
            chk("idle_pending", {26'd0, pending}, 32'd0);
            chk("idle_served", {31'd0, served}, 32'd0);
        end

        // Single 4D call with exact latency.
        btn_dn = 3'b100;
        tick();
        btn_dn = 3'd0;
        m_pend[5] = 1'b1;
        chk("latch_4d", {26'd0, pending}, 32'h20);
        chk("latch_cycle_idle", {29'd0, req_code}, 32'd0);
        tick();
        chk("issue_4d", {29'd0, req_code}, 32'd4);
        serve_next(0, 1'b0);

        // Round-robin: 1U, 3U, 2D from pointer 0, then 3D ahead of 1U from pointer 4.
        press(6'b001101);
        serve_next(1, 1'b0);
        serve_next(0, 1'b0);
        serve_next(2, 1'b0);
        chk("rr_ptr_model", m_ptr, 32'd4);
        press(6'b010001);
        chk("rr_first_3d", model_grant(), 32'd4);
        serve_next(0, 1'b0);
        serve_next(0, 1'b0);

        // Held 2U: cleared on retire, re-latched the next cycle.
        btn_up = 3'b010;
        m_pend[1] = 1'b1;
        serve_next(1, 1'b0);
        chk("hold_relatch", {31'd0, pending[1]}, 32'd1);
        btn_up = 3'd0;
        m_pend[1] = 1'b1;
        serve_next(0, 1'b0);

        // Randomized call mixes with presses during ISSUE.
        for (int r = 0; r < 10; r++) begin
            if (model_grant() < 0) press(6'($urandom_range(1, 63)));
            serve_next($urandom_range(0, 3), 1'b1);
        end
        while (model_grant() >= 0) serve_next(0, 1'b0);

`ifdef LIFT_CALL_TIMEOUT_EN
        // 2U never served: abandoned after TMO cycles, 3D granted next.
        press(6'b010010);
        wait_valid();
        chk("to_grant_2u", {29'd0, req_code}, 32'd2);
        for (int k = 1; k < TMO; k++) begin
            tick();
            chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
        end
        tick();
        chk("to_err_set", {31'd0, timeout_err}, 32'd1);
        chk("to_code_none", {29'd0, req_code}, 32'd0);
        chk("to_pending_kept", {26'd0, pending}, 32'h12);
        chk("to_no_served", {31'd0, served}, 32'd0);
        m_ptr = 2;
        tick();
        chk("to_next_3d", {29'd0, req_code}, 32'd7);
        serve_next(0, 1'b0);
        serve_next(0, 1'b0);
        chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
        chk("timeout_tied_low", {31'd0, timeout_err}, 32'd0);
`endif

        // Asynchronous reset in the middle of a dwell.
        press(6'b000100);
        wait_valid();
        chk("pre_rst_code", {29'd0, req_code}, 32'd3);
        floor_at = 2'b10;
        lift_dir = 2'b10;
        tick();
        lift_dir = 2'b00;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_code", {29'd0, req_code}, 32'd0);
        chk("arst_valid", {31'd0, req_valid}, 32'd0);
        chk("arst_pending", {26'd0, pending}, 32'd0);
        chk("arst_served", {31'd0, served}, 32'd0);
        chk("arst_timeout", {31'd0, timeout_err}, 32'd0);
        for (int k = 0; k < DWELL; k++) begin
            tick();
            chk("arst_no_served", {31'd0, served}, 32'd0);
        end
        rst_n = 1'b1;
        model_reset();
        press(6'b100001);
        serve_next(0, 1'b0);
        serve_next(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lift_call_encoder.md
Name: lift_call_encoder

Overview:
- Hall-call front end for the lift controller: latches the six hall-call buttons (1U, 2U, 3U, 2D, 3D, 4D).
- Arbitrates the pending calls round-robin and drives one 3-bit encoded request into the lift FSM's request input.
- Watches the lift FSM's UP/DOWN/STAY output and the floor sensor to detect service.
- Holds the request through a door dwell, then retires it.

Parameters:
- DWELL_CYCLES, 8, cycles the served request is held after arrival (door dwell); legal range 1..255.
- TIMEOUT_CYCLES, 1024, max ISSUE cycles before abandoning a request; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_up  in  3  hall up buttons, bit0=floor1, bit1=floor2, bit2=floor3; level, may be held.
- btn_dn  in  3  hall down buttons, bit0=floor2, bit1=floor3, bit2=floor4.
- lift_dir  in  2  lift FSM output: 00=UP, 01=DOWN, 10=STAY, 11=illegal (treated as moving).
- floor_at  in  2  current floor from the sensor: 00=floor1 … 11=floor4.
- req_code  out  3  encoded request to the lift FSM: 001=1U, 010=2U, 011=3U, 110=2D, 111=3D, 100=4D, 000=none.
- req_valid  out  1  high whenever req_code is nonzero.
- served  out  1  one-cycle pulse when a request retires.
- pending  out  6  latched calls; index order is 1U, 2U, 3U, 2D, 3D, 4D (bit0..bit5).
- timeout_err  out  1  sticky error flag; present only with LIFT_CALL_TIMEOUT_EN, otherwise tied 0.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pending=0, rr_ptr=0, dwell_cnt=0.
  - req_code=000, req_valid=0, served=0, timeout_err=0.
  - A reset mid-operation drops all calls and the active request immediately.
- Latching:
  - Each cycle, pending |= {btn_dn, btn_up}.
  - A press on an already-pending bit has no effect.
  - A press on the active index during DWELL is absorbed, i.e. not re-latched.
  - On the retire edge, clear wins over a same-cycle press of that index.
- Arbitration:
  - Round-robin search starting at rr_ptr, wrapping 5→0.
  - After a retire, rr_ptr = active index + 1 mod 6.
- Target floor per index: 1U→1, 2U→2, 3U→3, 2D→2, 3D→3, 4D→4.
- FSM:
  - IDLE: req_code=000. If pending≠0, latch the granted index as active and go to ISSUE.
    - Latency: press sampled at edge t sets pending; ISSUE (req_code valid) from edge t+1.
  - ISSUE: req_code = code(active).
    - If floor_at==target and lift_dir==STAY: load dwell_cnt=DWELL_CYCLES-1, go to DWELL.
  - DWELL: req_code held.
    - Decrement dwell_cnt each cycle.
    - At 0: clear pending[active], pulse served, advance rr_ptr, go to IDLE.
- Outputs are registered.
- req_code never changes while in ISSUE or DWELL.
- Returning to IDLE costs one cycle with req_code=000 between requests.
- lift_dir changing away from STAY during DWELL does not abort the dwell.

Optional Feature:
- Macro: LIFT_CALL_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter runs in ISSUE.
  - When it reaches TIMEOUT_CYCLES: set timeout_err (sticky until reset), leave pending[active] set, set rr_ptr = active+1, go to IDLE without pulsing served.
- Without the macro: no counter; ISSUE waits indefinitely; timeout_err tied 0.

Decomposition:
- Shared package lift_pkg holds:
  - dir codes UP/DOWN/STAY;
  - the six request codes;
  - the state enum IDLE/ISSUE/DWELL;
  - functions idx→code and idx→target floor.
  - The lift FSM imports the same constants.
- One sub-module: lift_rr_arbiter.
  - Purely combinational.
  - Inputs: pending[5:0], rr_ptr[2:0].
  - Outputs: grant_idx[2:0], grant_vld.

Test Plan:
- Reset then idle: no buttons for 20 cycles → req_code=000, pending=0, served=0 throughout.
- Single call: pulse btn_dn[2] (4D) one cycle.
  - Expect pending=100000 next edge and req_code=100 the edge after.
  - Drive floor_at=11, lift_dir=10 → served pulses exactly DWELL_CYCLES cycles later.
  - pending returns to 0 and req_code returns to 000.
- Round-robin: press 1U, 3U, 2D together with rr_ptr=0.
  - Serve each in turn → order 001, 011, 110.
  - Then re-press 1U while 3D is pending with rr_ptr=4 → 3D (111) granted before 1U.
- Boundary: hold btn_up[1] (2U) continuously while 2U dwells.
  - Expect no re-latch during DWELL and pending[1] clear on the retire edge.
  - pending[1] re-latches the following cycle because the button is still held.
- Reset mid-DWELL: assert rst_n low asynchronously mid-dwell → outputs zero immediately, no served pulse.
- LIFT_CALL_TIMEOUT_EN with TIMEOUT_CYCLES=16: issue 2U, keep lift_dir=00.
  - After 16 cycles timeout_err=1, pending[1] still set, req_code drops to 000.
  - The next pending call is granted.
